// File: rtl/adain_pkg.sv
// Shared encodings and sizing helpers for the AdaIN control unit.
package adain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEAN = 3'd1,
        ST_VAR  = 3'd2,
        ST_ISIG = 3'd3,
        ST_B1   = 3'd4,
        ST_B0   = 3'd5,
        ST_NORM = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'b00,
        MODE_MEAN  = 2'b01,
        MODE_STATS = 2'b10,
        MODE_NORM  = 2'b11
    } mode_t;

    localparam logic [1:0] DONE_NONE  = 2'b00;
    localparam logic [1:0] DONE_MEAN  = 2'b01;
    localparam logic [1:0] DONE_STATS = 2'b10;
    localparam logic [1:0] DONE_NORM  = 2'b11;

    localparam int W_MAX_DEF = 256;
    localparam int H_MAX_DEF = 256;
    localparam int C_MAX_DEF = 512;

    // Width of a counter that runs 0..max_val-1 (never zero bits wide).
    function automatic int cnt_w(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    // Completion code reported for a given operating mode.
    function automatic logic [1:0] done_code_of(input mode_t m);
        case (m)
            MODE_MEAN:  return DONE_MEAN;
            MODE_STATS: return DONE_STATS;
            default:    return DONE_NORM;
        endcase
    endfunction

endpackage

// File: rtl/adain_ctrl_mc_if.sv
// Command, pixel-stream and datapath-strobe bundle of the AdaIN controller.
interface adain_ctrl_mc_if #(
    parameter int W_MAX = adain_pkg::W_MAX_DEF,
    parameter int H_MAX = adain_pkg::H_MAX_DEF,
    parameter int C_MAX = adain_pkg::C_MAX_DEF
);
    localparam int WW = $clog2(W_MAX + 1);
    localparam int HW = $clog2(H_MAX + 1);
    localparam int NW = $clog2(C_MAX + 1);
    localparam int IW = adain_pkg::cnt_w(C_MAX);

    logic          start;
    logic [1:0]    mode;
    logic [WW-1:0] width;
    logic [HW-1:0] height;
    logic [NW-1:0] n_ch;
    logic          in_valid;
    logic          in_ready;
    logic          input_mac_en;
    logic          rst_acc;
    logic          mean_en;
    logic          variance_en;
    logic          inv_sigma_en;
    logic          B1_en;
    logic          B0_en;
    logic          out_en;
    logic [IW-1:0] ch_idx;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic [1:0]    done_code;

    modport master (
        output start, mode, width, height, n_ch, in_valid,
        input  in_ready, input_mac_en, rst_acc, mean_en, variance_en,
               inv_sigma_en, B1_en, B0_en, out_en, ch_idx, state, busy,
               done, done_code
    );

    modport slave (
        input  start, mode, width, height, n_ch, in_valid,
        output in_ready, input_mac_en, rst_acc, mean_en, variance_en,
               inv_sigma_en, B1_en, B0_en, out_en, ch_idx, state, busy,
               done, done_code
    );

endinterface

// File: rtl/adain_beat_delay.sv
// Delay line for the accepted-beat and first-beat flags of a stream phase.
// It shifts every cycle regardless of stalls so in-flight beats keep emerging.
module adain_beat_delay #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic beat,
    input  logic first,
    output logic beat_m1,
    output logic beat_m,
    output logic first_m1
);
    logic [LAT:1]   beat_pipe;
    logic [LAT-1:1] first_pipe;

    // Shift both flags one stage per cycle; reset empties the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_pipe  <= '0;
            first_pipe <= '0;
        end else begin
            beat_pipe[1]  <= beat;
            first_pipe[1] <= first;
            for (int i = 2; i <= LAT; i++) beat_pipe[i] <= beat_pipe[i-1];
            for (int i = 2; i < LAT; i++) first_pipe[i] <= first_pipe[i-1];
        end
    end

    assign beat_m1  = beat_pipe[LAT-1];
    assign beat_m   = beat_pipe[LAT];
    assign first_m1 = first_pipe[LAT-1];

endmodule

// File: rtl/adain_ctrl_mc.sv
// Multi-channel AdaIN sequencer: runs MEAN/VAR/ISIG/B1/B0/NORM per channel
// over an HxW map, pacing pixel beats through a valid/ready stall handshake.
module adain_ctrl_mc import adain_pkg::*; #(
    parameter int W_MAX    = W_MAX_DEF,
    parameter int H_MAX    = H_MAX_DEF,
    parameter int C_MAX    = C_MAX_DEF,
    parameter int LAT_MAC  = 3,
    parameter int LAT_ISIG = 4,
    parameter int LAT_AFF  = 3
) (
    input logic           clk,
    input logic           rst,
    adain_ctrl_mc_if.slave bus
);
    localparam int WW   = $clog2(W_MAX + 1);
    localparam int HW   = $clog2(H_MAX + 1);
    localparam int NW   = $clog2(C_MAX + 1);
    localparam int XW   = cnt_w(W_MAX);
    localparam int YW   = cnt_w(H_MAX);
    localparam int IW   = cnt_w(C_MAX);
    localparam int LMX1 = (LAT_MAC > LAT_ISIG) ? LAT_MAC : LAT_ISIG;
    localparam int LMAX = (LMX1 > LAT_AFF) ? LMX1 : LAT_AFF;
    localparam int KW   = $clog2(LMAX + 1);

    state_t        state, state_nx;
    mode_t         mode_q, mode_in;
    logic [WW-1:0] w_q;
    logic [HW-1:0] h_q;
    logic [NW-1:0] c_q;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [KW-1:0] k;          // drain counter in stream phases, step counter otherwise
    logic          drain;
    logic [IW-1:0] ch;
    logic          done_q;
    logic [1:0]    code_q;

    logic stream, in_ready, acc, col_end, row_end, first, last;
    logic zero_sz, start_ok, drain_end, more_ch;
    logic phase_end, ch_step;
    logic mac_en, rst_acc, mean_en, var_en, isig_en, b1_en, b0_en, out_en;
    logic beat_m1, beat_m, first_m1;

    assign mode_in   = mode_t'(bus.mode);
    assign stream    = (state == ST_MEAN) || (state == ST_VAR) || (state == ST_NORM);
    assign in_ready  = stream && !drain;
    assign acc       = in_ready && bus.in_valid;
    assign col_end   = (WW'(col) == w_q - WW'(1));
    assign row_end   = (HW'(row) == h_q - HW'(1));
    assign first     = acc && (col == '0) && (row == '0);
    assign last      = acc && col_end && row_end;
    assign drain_end = drain && (k == KW'(LAT_MAC));
    assign more_ch   = (NW'(ch) + NW'(1)) < c_q;
    // A done cycle swallows start so back-to-back requests are spaced by one cycle.
    assign start_ok  = (state == ST_IDLE) && bus.start && !done_q;
    assign zero_sz   = (bus.width == '0) || (bus.height == '0) ||
                       ((mode_in == MODE_FULL) && (bus.n_ch == '0));

    adain_beat_delay #(.LAT(LAT_MAC)) u_beat_delay (
        .clk      (clk),
        .rst      (rst),
        .beat     (acc),
        .first    (first),
        .beat_m1  (beat_m1),
        .beat_m   (beat_m),
        .first_m1 (first_m1)
    );

    // Next-state selection and per-state datapath strobes.
    always_comb begin
        state_nx  = state;
        phase_end = 1'b0;
        ch_step   = 1'b0;
        mac_en    = 1'b0;
        rst_acc   = 1'b0;
        mean_en   = 1'b0;
        var_en    = 1'b0;
        isig_en   = 1'b0;
        b1_en     = 1'b0;
        b0_en     = 1'b0;
        out_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok && !zero_sz) begin
                    case (mode_in)
                        MODE_STATS: state_nx = ST_VAR;
                        MODE_NORM:  state_nx = ST_NORM;
                        default:    state_nx = ST_MEAN;
                    endcase
                end
            end
            ST_MEAN: begin
                mac_en  = acc;
                rst_acc = first_m1;
                if (drain_end) begin
                    mean_en   = 1'b1;
                    phase_end = 1'b1;
                    state_nx  = (mode_q == MODE_MEAN) ? ST_IDLE : ST_VAR;
                end
            end
            ST_VAR: begin
                mac_en  = acc;
                rst_acc = first_m1;
                if (drain_end) begin
                    var_en    = 1'b1;
                    phase_end = 1'b1;
                    state_nx  = ST_ISIG;
                end
            end
            ST_ISIG: begin
                mac_en  = (k == KW'(1));
                rst_acc = (k == KW'(LAT_ISIG - 1));
                if (k == KW'(LAT_ISIG)) begin
                    isig_en   = 1'b1;
                    phase_end = 1'b1;
                    state_nx  = ST_B1;
                end
            end
            ST_B1: begin
                mac_en  = (k == '0);
                rst_acc = (k == KW'(LAT_AFF - 1));
                if (k == KW'(LAT_AFF)) begin
                    b1_en     = 1'b1;
                    phase_end = 1'b1;
                    state_nx  = ST_B0;
                end
            end
            ST_B0: begin
                mac_en  = (k == '0);
                rst_acc = (k == KW'(LAT_AFF - 1));
                if (k == KW'(LAT_AFF)) begin
                    b0_en     = 1'b1;
                    phase_end = 1'b1;
                    state_nx  = (mode_q == MODE_STATS) ? ST_IDLE : ST_NORM;
                end
            end
            ST_NORM: begin
                mac_en  = acc;
                rst_acc = beat_m1;
                out_en  = beat_m;
                if (drain_end) begin
                    phase_end = 1'b1;
                    if ((mode_q == MODE_FULL) && more_ch) begin
                        ch_step  = 1'b1;
                        state_nx = ST_MEAN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, configuration latch, beat/step counters and completion reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_FULL;
            w_q    <= '0;
            h_q    <= '0;
            c_q    <= '0;
            col    <= '0;
            row    <= '0;
            k      <= '0;
            drain  <= 1'b0;
            ch     <= '0;
            done_q <= 1'b0;
            code_q <= DONE_NONE;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            if (start_ok) begin
                mode_q <= mode_in;
                w_q    <= bus.width;
                h_q    <= bus.height;
                c_q    <= bus.n_ch;
                if (zero_sz) begin
                    done_q <= 1'b1;
                    code_q <= done_code_of(mode_in);
                end
            end
            if (phase_end) begin
                col   <= '0;
                row   <= '0;
                k     <= '0;
                drain <= 1'b0;
                if (state_nx == ST_IDLE) begin
                    done_q <= 1'b1;
                    code_q <= done_code_of(mode_q);
                    ch     <= '0;
                end else if (ch_step) begin
                    ch <= ch + 1'b1;
                end
            end else begin
                if (acc) begin
                    if (col_end) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (last) begin
                        drain <= 1'b1;
                        k     <= KW'(1);
                    end
                end
                if (drain || (state == ST_ISIG) || (state == ST_B1) || (state == ST_B0))
                    k <= k + 1'b1;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.input_mac_en = mac_en;
    assign bus.rst_acc      = rst_acc;
    assign bus.mean_en      = mean_en;
    assign bus.variance_en  = var_en;
    assign bus.inv_sigma_en = isig_en;
    assign bus.B1_en        = b1_en;
    assign bus.B0_en        = b0_en;
    assign bus.out_en       = out_en;
    assign bus.ch_idx       = ch;
    assign bus.state        = state;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.done_code    = code_q;

endmodule

// File: tb/tb_adain_ctrl_mc.sv
// Bench for adain_ctrl_mc: a schedule model predicts every output on every
// cycle of a transaction; a negedge process compares the DUT against it.
module tb_adain_ctrl_mc;
    localparam int LM   = 3;
    localparam int LI   = 4;
    localparam int LA   = 3;
    localparam int NCYC = 1024;

    typedef struct packed {
        logic       in_ready;
        logic       mac;
        logic       rst_acc;
        logic       mean;
        logic       var_en;
        logic       isig;
        logic       b1;
        logic       b0;
        logic       out_en;
        logic [8:0] ch;
        logic [2:0] st;
        logic       busy;
        logic       done;
        logic [1:0] code;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adain_ctrl_mc_if bus ();

    adain_ctrl_mc #(.LAT_MAC(LM), .LAT_ISIG(LI), .LAT_AFF(LA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t       exp_o [NCYC];
    bit         vseq  [NCYC];
    int         cyc;
    bit         chk_en;
    int         checks;
    int         errors;
    logic [1:0] last_code;
    int ev_rst, ev_mac, ev_mean, ev_var, ev_isig, ev_b1, ev_b0, ev_done;
    int n_out, n_done, max_ch;
    obs_t       cur_obs;

    function automatic obs_t sample();
        obs_t o;
        o.in_ready = bus.in_ready;
        o.mac      = bus.input_mac_en;
        o.rst_acc  = bus.rst_acc;
        o.mean     = bus.mean_en;
        o.var_en   = bus.variance_en;
        o.isig     = bus.inv_sigma_en;
        o.b1       = bus.B1_en;
        o.b0       = bus.B0_en;
        o.out_en   = bus.out_en;
        o.ch       = bus.ch_idx;
        o.st       = bus.state;
        o.busy     = bus.busy;
        o.done     = bus.done;
        o.code     = bus.done_code;
        return o;
    endfunction

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    // ---------------- schedule model ----------------
    task automatic mark(input int a, input int b, input int st, input int ch);
        for (int i = a; i <= b; i++) begin
            exp_o[i].st   = 3'(st);
            exp_o[i].busy = 1'b1;
            exp_o[i].ch   = 9'(ch);
        end
    endtask

    // Stream phase of n beats starting at cycle p; p returns the next phase start.
    task automatic stream_ph(input int st, input int ch, input int n, inout int p);
        int cur, f, l;
        cur = p; f = -1; l = p;
        for (int i = 0; i < n; i++) begin
            while (!vseq[cur] && cur < NCYC - 16) begin
                exp_o[cur].in_ready = 1'b1;
                cur++;
            end
            exp_o[cur].in_ready = 1'b1;
            exp_o[cur].mac      = 1'b1;
            if (i == 0) f = cur;
            if (st == 6) begin
                exp_o[cur + LM - 1].rst_acc = 1'b1;
                exp_o[cur + LM].out_en      = 1'b1;
            end
            l = cur;
            cur++;
        end
        if (st != 6) exp_o[f + LM - 1].rst_acc = 1'b1;
        if (st == 1) exp_o[l + LM].mean   = 1'b1;
        if (st == 2) exp_o[l + LM].var_en = 1'b1;
        mark(p, l + LM, st, ch);
        p = l + LM + 1;
    endtask

    // Fixed-length phase of L+1 cycles with the MAC enable at step mo.
    task automatic fixed_ph(input int st, input int ch, input int len, input int mo, inout int p);
        mark(p, p + len, st, ch);
        exp_o[p + mo].mac          = 1'b1;
        exp_o[p + len - 1].rst_acc = 1'b1;
        if (st == 3) exp_o[p + len].isig = 1'b1;
        if (st == 4) exp_o[p + len].b1   = 1'b1;
        if (st == 5) exp_o[p + len].b0   = 1'b1;
        p = p + len + 1;
    endtask

    // Fill exp_o for a start at cycle 0; e returns the last busy cycle (0 if none).
    task automatic build(input int md, input int w, input int h, input int c,
                         input int rst_at, output int e);
        int p, nch;
        logic [1:0] code;
        for (int i = 0; i < NCYC; i++) begin
            exp_o[i]      = '0;
            exp_o[i].code = last_code;
        end
        code = (md == 1) ? 2'b01 : (md == 2) ? 2'b10 : 2'b11;
        if (w == 0 || h == 0 || (md == 0 && c == 0)) begin
            e = 0;
        end else begin
            p   = 1;
            nch = (md == 0) ? c : 1;
            for (int ch = 0; ch < nch; ch++) begin
                if (md == 0 || md == 1) stream_ph(1, ch, w * h, p);
                if (md == 0 || md == 2) begin
                    stream_ph(2, ch, w * h, p);
                    fixed_ph(3, ch, LI, 1, p);
                    fixed_ph(4, ch, LA, 0, p);
                    fixed_ph(5, ch, LA, 0, p);
                end
                if (md == 0 || md == 3) stream_ph(6, ch, w * h, p);
            end
            e = p - 1;
        end
        exp_o[e + 1].done = 1'b1;
        for (int i = e + 1; i < NCYC; i++) exp_o[i].code = code;
        if (rst_at >= 0) begin
            for (int i = rst_at + 1; i < NCYC; i++) exp_o[i] = '0;
            last_code = 2'b00;
        end else begin
            last_code = code;
        end
    endtask

    task automatic vfill(input int stall);
        for (int i = 0; i < NCYC; i++) vseq[i] = ($urandom_range(0, 99) >= stall);
    endtask

    // Run one transaction; optionally a stray start while busy (xs_en) and a reset.
    task automatic run(input int md, input int w, input int h, input int c,
                       input int rst_at, input bit xs_en);
        int e, xs, len;
        logic [31:0] r;
        build(md, w, h, c, rst_at, e);
        xs  = (xs_en && e >= 1) ? $urandom_range(1, e) : -1;
        len = e + 3;
        ev_rst = -1; ev_mac = -1; ev_mean = -1; ev_var = -1; ev_isig = -1;
        ev_b1 = -1; ev_b0 = -1; ev_done = -1; n_out = 0; n_done = 0; max_ch = 0;
        for (int n = 0; n <= len; n++) begin
            @(posedge clk);
            #1;
            cyc    = n;
            chk_en = 1'b1;
            rst    = (n == rst_at);
            bus.start = (n == 0) || (n == xs) || (n == e + 1 && rst_at < 0);
            r = $urandom;
            if (n == 0) begin
                bus.mode   = md[1:0];
                bus.width  = w[8:0];
                bus.height = h[8:0];
                bus.n_ch   = c[9:0];
            end else begin
                bus.mode   = r[1:0];
                bus.width  = r[10:2];
                bus.height = r[19:11];
                bus.n_ch   = r[29:20];
            end
            bus.in_valid = vseq[n];
        end
        @(negedge clk);
        #1;
        chk_en    = 1'b0;
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    // Per-cycle comparison against the model plus event capture for literal checks.
    always @(negedge clk) begin
        if (chk_en) begin
            cur_obs = sample();
            checks++;
            if (cur_obs !== exp_o[cyc]) begin
                errors++;
                $display("FAIL outputs cyc=%0d: got %h, expected %h", cyc, cur_obs, exp_o[cyc]);
            end
            if (cur_obs.rst_acc && ev_rst < 0) ev_rst = cyc;
            if (cur_obs.mac && ev_mac < 0) ev_mac = cyc;
            if (cur_obs.mean && ev_mean < 0) ev_mean = cyc;
            if (cur_obs.var_en && ev_var < 0) ev_var = cyc;
            if (cur_obs.isig && ev_isig < 0) ev_isig = cyc;
            if (cur_obs.b1 && ev_b1 < 0) ev_b1 = cyc;
            if (cur_obs.b0 && ev_b0 < 0) ev_b0 = cyc;
            if (cur_obs.done && ev_done < 0) ev_done = cyc;
            if (cur_obs.out_en) n_out++;
            if (cur_obs.done) n_done++;
            if (int'(cur_obs.ch) > max_ch) max_ch = int'(cur_obs.ch);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int md, w, h, c, st;
        checks = 0; errors = 0; chk_en = 1'b0; cyc = 0; last_code = 2'b00;
        bus.start = 1'b1; bus.mode = 2'b01; bus.width = 9'd2; bus.height = 9'd2;
        bus.n_ch = 10'd1; bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs zero", int'(sample()), 0);
        @(posedge clk);
        #1;
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);

        // mean, ideal stream
        vfill(0);
        run(1, 2, 2, 0, -1, 1'b1);
        chk("mean rst_acc cycle", ev_rst, 3);
        chk("mean mean_en cycle", ev_mean, 7);
        chk("mean done cycle", ev_done, 8);
        chk("mean done count", n_done, 1);

        // mean with stall in cycles 2-3
        vfill(0); vseq[2] = 1'b0; vseq[3] = 1'b0;
        run(1, 2, 2, 0, -1, 1'b0);
        chk("stall rst_acc cycle", ev_rst, 3);
        chk("stall mean_en cycle", ev_mean, 9);

        // stats sequence
        vfill(0);
        run(2, 3, 1, 0, -1, 1'b1);
        chk("stats variance_en cycle", ev_var, 6);
        chk("stats inv_sigma_en cycle", ev_isig, 11);
        chk("stats B1_en cycle", ev_b1, 15);
        chk("stats B0_en cycle", ev_b0, 19);
        chk("stats done cycle", ev_done, 20);

        // norm with a mid-stream stall
        vfill(0); vseq[4] = 1'b0; vseq[5] = 1'b0; vseq[6] = 1'b0;
        run(3, 4, 2, 0, -1, 1'b1);
        chk("norm out_en count", n_out, 8);
        chk("norm rst_acc first", ev_rst, 3);

        // full, three channels
        vfill(20);
        run(0, 2, 2, 3, -1, 1'b1);
        chk("full max ch_idx", max_ch, 2);
        chk("full done count", n_done, 1);
        chk("full out_en count", n_out, 12);

        // reset in VAR drain, then a fresh start
        vfill(0);
        run(2, 3, 1, 0, 5, 1'b0);
        chk("reset no variance_en", ev_var, -1);
        vfill(0);
        run(1, 2, 2, 0, -1, 1'b0);
        chk("after reset mean_en cycle", ev_mean, 7);

        // zero-size guards
        vfill(0);
        run(1, 0, 3, 0, -1, 1'b0);
        chk("W=0 done cycle", ev_done, 1);
        chk("W=0 no mac", ev_mac, -1);
        run(0, 2, 2, 0, -1, 1'b0);
        chk("C=0 done cycle", ev_done, 1);

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            md = $urandom_range(0, 3);
            w  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            h  = $urandom_range(1, 4);
            c  = $urandom_range(1, 3);
            st = $urandom_range(0, 40);
            vfill(st);
            run(md, w, h, c, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
